// File: rtl/row_clear_ctrl_if.sv
// row_clear_ctrl_if: placement handshake, detector link and status of the grid controller
interface row_clear_ctrl_if #(parameter int CNT_W = 8);
    logic             place_valid;
    logic [11:0]      place_mask;
    logic             place_ready;
    logic [11:0]      det_grid;
    logic [2:0]       det_f;
    logic [2:0]       row_cleared;
    logic [CNT_W-1:0] lines;
    logic             reject;
    logic             fault;
    modport master (
        output place_valid, place_mask, det_f,
        input  place_ready, det_grid, row_cleared, lines, reject, fault
    );
    modport slave (
        input  place_valid, place_mask, det_f,
        output place_ready, det_grid, row_cleared, lines, reject, fault
    );
endinterface

// File: rtl/row_clear_ctrl.sv
// row_clear_ctrl: owns the 4x3 grid, merges pieces and clears full rows one per cycle with gravity
module row_clear_ctrl #(
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           reset_n,
    row_clear_ctrl_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CHECK = 1'b1;
    logic [0:0]       state;
    logic [11:0]      grid;
    logic [11:0]      cleared_grid;
    logic [CNT_W-1:0] lines;
    logic [2:0]       row_cleared;
    logic             reject;
    logic             fault;
    logic             one_hot;
    assign one_hot = bus.det_f inside {3'b001, 3'b010, 3'b100};
    // rows above the cleared one fall by one; rows below keep their contents
    always_comb begin
        cleared_grid = bus.det_f[0] ? {grid[11:4], 4'h0} :
                       bus.det_f[1] ? {grid[11:8], grid[3:0], 4'h0} :
                                      {grid[7:0], 4'h0};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grid        <= '0;
            lines       <= '0;
            row_cleared <= '0;
            reject      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            row_cleared <= '0;
            reject      <= 1'b0;
            if (state == IDLE) begin
                if (bus.place_valid) begin
                    if (|(bus.place_mask & grid)) begin
                        reject <= 1'b1;
                    end else begin
                        grid  <= grid | bus.place_mask;
                        state <= CHECK;
                    end
                end
            end else if (bus.det_f == 3'b000) begin
                state <= IDLE;
            end else if (one_hot) begin
                grid        <= cleared_grid;
                row_cleared <= bus.det_f;
                if (lines != '1) lines <= lines + 1'b1;
            end else begin
                fault <= 1'b1;
                state <= IDLE;
            end
        end
    end
    assign bus.place_ready = (state == IDLE);
    assign bus.det_grid    = grid;
    assign bus.row_cleared = row_cleared;
    assign bus.lines       = lines;
    assign bus.reject      = reject;
    assign bus.fault       = fault;
endmodule

// File: tb/tb_row_clear_ctrl.sv
// tb_row_clear_ctrl: directed steps with a row-clear scoreboard and a behavioural full-row detector
module tb_row_clear_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic force_f = 1'b0;
    int tests = 0;
    int fails = 0;
    int mg_lines = 0;
    logic [11:0] mg = '0;
    typedef struct {
        logic [2:0]  rc;
        logic        rej;
        logic [11:0] g;
    } exp_t;
    exp_t sb[$];
    row_clear_ctrl_if #(.CNT_W(8)) bus ();
    row_clear_ctrl #(.CNT_W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    // downstream detector: reports the topmost full row, or an illegal code on request
    always_comb begin
        bus.det_f = force_f                   ? 3'b011 :
                    (bus.det_grid[3:0]  == 4'hF) ? 3'b001 :
                    (bus.det_grid[7:4]  == 4'hF) ? 3'b010 :
                    (bus.det_grid[11:8] == 4'hF) ? 3'b100 : 3'b000;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    always @(negedge clk) begin
        if (reset_n && (bus.row_cleared != 3'b000 || bus.reject)) begin
            chk("pulse_exclusive", {31'd0, bus.row_cleared != 3'b000 && bus.reject}, 0);
            chk("sb_nonempty", {31'd0, sb.size() != 0}, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_row_cleared", {29'd0, bus.row_cleared}, {29'd0, e.rc});
                chk("sb_reject", {31'd0, bus.reject}, {31'd0, e.rej});
                chk("sb_grid", {20'd0, bus.det_grid}, {20'd0, e.g});
            end
        end
    end
    task automatic place(input logic [11:0] m);
        logic [3:0] r [3];
        logic       rej;
        int         k;
        int         e;
        int         full;
        rej = (m & mg) != 0;
        k = 0;
        if (rej) begin
            sb.push_back('{3'b000, 1'b1, mg});
        end else begin
            mg = mg | m;
            for (int i = 0; i < 3; i++) r[i] = mg[4*i +: 4];
            forever begin
                full = -1;
                for (int i = 2; i >= 0; i--) if (r[i] == 4'hF) full = i;
                if (force_f || full < 0) break;
                for (int j = full; j > 0; j--) r[j] = r[j-1];
                r[0] = 4'h0;
                mg = {r[2], r[1], r[0]};
                if (mg_lines < 255) mg_lines++;
                sb.push_back('{3'(1 << full), 1'b0, mg});
                k++;
            end
        end
        @(negedge clk);
        chk("ready_before_place", {31'd0, bus.place_ready}, 1);
        bus.place_valid = 1'b1;
        bus.place_mask  = m;
        @(posedge clk);
        @(negedge clk);
        bus.place_valid = 1'b0;
        bus.place_mask  = '0;
        e = 0;
        while (!bus.place_ready && e < 20) begin
            @(negedge clk);
            e++;
        end
        chk("ready_latency", e, rej ? 0 : k + 1);
        chk("grid", {20'd0, bus.det_grid}, {20'd0, mg});
        chk("lines", {24'd0, bus.lines}, mg_lines);
    endtask
    task automatic do_reset;
        @(negedge clk);
        reset_n = 1'b0;
        sb.delete();
        mg = '0;
        mg_lines = 0;
        force_f = 1'b0;
        #2;
        @(negedge clk);
        reset_n = 1'b1;
    endtask
    initial begin
        bus.place_valid = 1'b0;
        bus.place_mask  = '0;
        #3;
        chk("rst_grid", {20'd0, bus.det_grid}, 0);
        chk("rst_ready", {31'd0, bus.place_ready}, 1);
        chk("rst_lines", {24'd0, bus.lines}, 0);
        chk("rst_fault", {31'd0, bus.fault}, 0);
        chk("rst_pulses", {28'd0, bus.row_cleared, bus.reject}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        place(12'h00F);
        do_reset();
        place(12'h3F1);
        do_reset();
        place(12'h0A5);
        place(12'h001);
        chk("reject_ready", {31'd0, bus.place_ready}, 1);
        place(12'hF5A);
        chk("cascade_lines", {24'd0, bus.lines}, 3);
        do_reset();
        sb.push_back('{3'b001, 1'b0, 12'hFF0});
        @(negedge clk);
        bus.place_valid = 1'b1;
        bus.place_mask  = 12'hFFF;
        @(posedge clk);
        @(negedge clk);
        bus.place_valid = 1'b0;
        bus.place_mask  = '0;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midclr_grid", {20'd0, bus.det_grid}, 0);
        chk("midclr_lines", {24'd0, bus.lines}, 0);
        chk("midclr_ready", {31'd0, bus.place_ready}, 1);
        chk("midclr_row_cleared", {29'd0, bus.row_cleared}, 0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        force_f = 1'b1;
        place(12'h123);
        chk("fault_set", {31'd0, bus.fault}, 1);
        force_f = 1'b0;
        place(12'h800);
        chk("fault_sticky", {31'd0, bus.fault}, 1);
        do_reset();
        chk("fault_cleared", {31'd0, bus.fault}, 0);
        for (int i = 0; i < 256; i++) place(12'h00F);
        chk("sat_lines", {24'd0, bus.lines}, 255);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
